// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end that shares one binary-GCD core among NUM_REQ requesters.
// Optional core watchdog enabled by defining GCD_SCHED_TIMEOUT_EN.
module gcd_rr_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned ID_W          = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic                    resp_valid,
    output logic [ID_W-1:0]         resp_id,
    output logic [31:0]             resp_r,
    output logic                    resp_err,
    output logic                    core_start,
    output logic [31:0]             core_a,
    output logic [31:0]             core_b,
    input  logic                    core_ready,
    input  logic                    core_done,
    input  logic [31:0]             core_r,
    output logic                    core_abort
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("gcd_rr_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES nonzero");
    end

    logic [1:0]         r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [31:0]        r_op_a;
    logic [31:0]        r_op_b;
    logic [31:0]        r_result;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_resp_valid;
    logic [ID_W-1:0]    r_resp_id;
    logic [31:0]        r_resp_r;
    logic               r_core_start;
    logic [31:0]        r_core_a;
    logic [31:0]        r_core_b;

    logic               w_found;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W-1:0]    w_cand;
    logic [31:0]        w_win_a;
    logic [31:0]        w_win_b;
    logic [ID_W-1:0]    w_ptr_next;

    // First asserted requester scanning upward from the pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = ID_W'((32'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_win_a    = req_a[32*w_winner +: 32];
    assign w_win_b    = req_b[32*w_winner +: 32];
    assign w_ptr_next = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

`ifdef GCD_SCHED_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;
    logic        r_tmo_hit;
    logic        r_resp_err;
    logic        r_core_abort;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_id         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_result     <= '0;
            r_ack        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_r     <= '0;
            r_core_start <= 1'b0;
            r_core_a     <= '0;
            r_core_b     <= '0;
`ifdef GCD_SCHED_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_tmo_hit    <= 1'b0;
            r_resp_err   <= 1'b0;
            r_core_abort <= 1'b0;
`endif
        end else begin
            r_ack        <= '0;
            r_resp_valid <= 1'b0;
            r_core_start <= 1'b0;
`ifdef GCD_SCHED_TIMEOUT_EN
            r_core_abort <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found && core_ready) begin
                        r_ack  <= NUM_REQ'(1) << w_winner;
                        r_id   <= w_winner;
                        r_op_a <= w_win_a;
                        r_op_b <= w_win_b;
`ifdef GCD_SCHED_TIMEOUT_EN
                        r_tmo_hit <= 1'b0;
`endif
                        // The core never finishes on a zero operand; answer a|b directly.
                        if (w_win_a == 32'd0 || w_win_b == 32'd0) begin
                            r_result <= w_win_a | w_win_b;
                            r_state  <= S_RESP;
                        end else begin
                            r_state  <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_core_start <= 1'b1;
                    r_core_a     <= r_op_a;
                    r_core_b     <= r_op_b;
                    r_state      <= S_WAIT;
`ifdef GCD_SCHED_TIMEOUT_EN
                    r_tmo_cnt    <= '0;
`endif
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_result <= core_r;
                        r_state  <= S_RESP;
                    end
`ifdef GCD_SCHED_TIMEOUT_EN
                    else if (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        r_core_abort <= 1'b1;
                        r_tmo_hit    <= 1'b1;
                        r_result     <= '0;
                        r_state      <= S_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 32'd1;
                    end
`endif
                end
                S_RESP: begin
                    r_resp_valid <= 1'b1;
                    r_resp_id    <= r_id;
                    r_resp_r     <= r_result;
                    r_ptr        <= w_ptr_next;
                    r_state      <= S_IDLE;
`ifdef GCD_SCHED_TIMEOUT_EN
                    r_resp_err   <= r_tmo_hit;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ack    = r_ack;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_r     = r_resp_r;
    assign core_start = r_core_start;
    assign core_a     = r_core_a;
    assign core_b     = r_core_b;

`ifdef GCD_SCHED_TIMEOUT_EN
    assign resp_err   = r_resp_err;
    assign core_abort = r_core_abort;
`else
    assign resp_err   = 1'b0;
    assign core_abort = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Scoreboard bench for gcd_rr_scheduler: random requesters, behavioural GCD core and
// round-robin reference; expectations follow GCD_SCHED_TIMEOUT_EN when it is defined.
module tb_gcd_rr_scheduler;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [N-1:0]      req_ack;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [31:0]       resp_r;
    logic              resp_err;
    logic              core_start;
    logic [31:0]       core_a;
    logic [31:0]       core_b;
    logic              core_ready;
    logic              core_done;
    logic [31:0]       core_r;
    logic              core_abort;

    logic              model_done;
    logic              inject_done;
    logic              core_hang;

    assign core_done = model_done | inject_done;

    gcd_rr_scheduler #(
        .NUM_REQ       (N),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ack   (req_ack),
        .resp_valid(resp_valid),
        .resp_id   (resp_id),
        .resp_r    (resp_r),
        .resp_err  (resp_err),
        .core_start(core_start),
        .core_a    (core_a),
        .core_b    (core_b),
        .core_ready(core_ready),
        .core_done (core_done),
        .core_r    (core_r),
        .core_abort(core_abort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[N][$];     // per requester: {err, result}
    logic [63:0] start_q[$];      // expected core operands {a, b}
    int          grants[$];
    int          m_ptr    = 0;
    int          inflight = -1;
    int          n_starts = 0;
    int          n_resp   = 0;
    int          n_abort  = 0;

    logic [N-1:0]    vld_snap;
    logic [32*N-1:0] a_snap;
    logic [32*N-1:0] b_snap;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x = a;
        logic [31:0] y = b;
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit all_queues_empty();
        for (int i = 0; i < N; i++) begin
            if (exp_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Inputs as the DUT saw them on the last rising edge.
    always @(posedge clk) begin
        vld_snap <= req_valid;
        a_snap   <= req_a;
        b_snap   <= req_b;
    end

    // Behavioural core: random latency, optional hang, reset/abort return it to idle.
    int          c_cnt;
    bit          c_busy;
    logic [31:0] c_res;
    always @(negedge clk) begin
        model_done = 1'b0;
        if (rst || core_abort) begin
            c_busy     = 1'b0;
            core_ready = 1'b1;
        end else if (core_start) begin
            c_busy     = 1'b1;
            core_ready = 1'b0;
            c_cnt      = $urandom_range(1, 6);
            c_res      = ref_gcd(core_a, core_b);
        end else if (c_busy && !core_hang) begin
            c_cnt--;
            if (c_cnt == 0) begin
                model_done = 1'b1;
                core_r     = c_res;
                c_busy     = 1'b0;
                core_ready = 1'b1;
            end
        end
    end

    // Monitor: grant prediction, core operand check, response scoreboard.
    int          w_act;
    int          w_pred;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [63:0] s_exp;
    logic [32:0] r_exp;
    always @(negedge clk) begin
        if (rst) begin
            m_ptr = 0;
            start_q.delete();
        end else begin
            if (req_ack != '0) begin
                chk("ack_onehot", $countones(req_ack), 1);
                w_act = -1;
                for (int k = 0; k < N; k++) if (req_ack[k]) w_act = k;
                w_pred = rr_pick(vld_snap, m_ptr);
                chk("ack_winner", w_act, w_pred);
                if (w_act >= 0) begin
                    grants.push_back(w_act);
                    inflight = w_act;
                    m_ptr    = (w_act + 1) % N;
                    m_a      = a_snap[32*w_act +: 32];
                    m_b      = b_snap[32*w_act +: 32];
                    if (m_a != 0 && m_b != 0) start_q.push_back({m_a, m_b});
                end
            end
            if (core_start) begin
                n_starts++;
                if (start_q.size() == 0) begin
                    chk("unexpected_core_start", 1, 0);
                end else begin
                    s_exp = start_q.pop_front();
                    chk("core_operands", {core_a, core_b}, s_exp);
                end
            end
            if (core_abort) n_abort++;
            if (resp_valid) begin
                n_resp++;
                chk("resp_id_owner", resp_id, inflight);
                if (exp_q[resp_id].size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    r_exp = exp_q[resp_id].pop_front();
                    chk("resp_err_r", {resp_err, resp_r}, r_exp);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) if (req_ack[i]) req_valid[i] = 1'b0;
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                         input bit hang);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_valid[i]      = 1'b1;
        if (!hang || a == 0 || b == 0) exp_q[i].push_back({1'b0, ref_gcd(a, b)});
`ifdef GCD_SCHED_TIMEOUT_EN
        else exp_q[i].push_back({1'b1, 32'h0});
`endif
    endtask

    task automatic rnd_pair(output logic [31:0] a, output logic [31:0] b);
        int unsigned sel = $urandom_range(0, 9);
        int unsigned g   = $urandom_range(1, 5000);
        a = g * $urandom_range(1, 50000);
        b = g * $urandom_range(1, 50000);
        case (sel)
            0: a = 32'd0;
            1: b = 32'd0;
            2: begin a = $urandom(); b = $urandom(); end
            3: begin a = $urandom(); b = a; end
            default: ;
        endcase
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while ((req_valid != '0 || !all_queues_empty() || start_q.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        chk(name, (req_valid == '0 && all_queues_empty() && start_q.size() == 0), 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ack"}, req_ack, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_id"}, resp_id, 0);
        chk({tag, "_resp_r"}, resp_r, 0);
        chk({tag, "_resp_err"}, resp_err, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_a"}, core_a, 0);
        chk({tag, "_core_b"}, core_b, 0);
        chk({tag, "_core_abort"}, core_abort, 0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
    endtask

    logic [31:0] ra;
    logic [31:0] rb;
    int          g0;
    int          s0;
    int          r0;
    int          a0;
    int          wn;

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        inject_done = 1'b0;
        core_hang   = 1'b0;
        core_ready  = 1'b1;
        model_done  = 1'b0;
        core_r      = '0;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;

        // Single core operation from requester 1.
        issue(1, 32'd48, 32'd18, 1'b0);
        wait_idle("drain_48_18", 100);

        // Zero operands bypass the core.
        s0 = n_starts;
        issue(2, 32'd0, 32'd35, 1'b0);
        wait_idle("drain_0_35", 100);
        issue(2, 32'd0, 32'd0, 1'b0);
        wait_idle("drain_0_0", 100);
        chk("zero_no_core_start", n_starts, s0);

        // All requesters continuously valid from reset.
        do_reset();
        g0 = grants.size();
        wn = 0;
        while (grants.size() < g0 + 5 && wn < 500) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    rnd_pair(ra, rb);
                    issue(i, ra, rb, 1'b0);
                end
            end
            tick();
            wn++;
        end
        wait_idle("drain_all_valid", 500);
        chk("grant_count", grants.size() >= g0 + 5, 1);
        for (int k = 0; k < 5; k++) begin
            if (grants.size() > g0 + k) chk($sformatf("grant_order_%0d", k), grants[g0 + k], k % N);
        end

        // core_done while idle must not produce a response.
        r0 = n_resp;
        inject_done = 1'b1;
        tick();
        inject_done = 1'b0;
        repeat (5) tick();
        chk("idle_done_ignored", n_resp, r0);

        // Reset during S_WAIT drops the op and clears the pointer.
        issue(1, 32'd9, 32'd6, 1'b0);
        wait_idle("drain_ptr_setup", 100);
        core_hang = 1'b1;
        s0 = n_starts;
        issue(2, 32'd100, 32'd75, 1'b1);
        wn = 0;
        while (n_starts == s0 && wn < 50) begin
            tick();
            wn++;
        end
        chk("hang_core_started", n_starts, s0 + 1);
        repeat (3) tick();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        check_zero("rst_wait");
        rst       = 1'b0;
        core_hang = 1'b0;
        exp_q[2].delete();
        r0 = n_resp;
        g0 = grants.size();
        issue(1, 32'd21, 32'd14, 1'b0);
        issue(3, 32'd27, 32'd36, 1'b0);
        wait_idle("drain_after_rst", 200);
        chk("rst_no_dropped_resp", n_resp, r0 + 2);
        if (grants.size() > g0) chk("rst_ptr_first_grant", grants[g0], 1);

        // Randomised traffic.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    rnd_pair(ra, rb);
                    issue(i, ra, rb, 1'b0);
                end
            end
            tick();
        end
        wait_idle("drain_random", 3000);

        // Core never finishes.
        core_hang = 1'b1;
        a0 = n_abort;
        r0 = n_resp;
        issue(0, 32'd12, 32'd8, 1'b1);
        repeat (40) tick();
`ifdef GCD_SCHED_TIMEOUT_EN
        chk("timeout_abort_pulse", n_abort, a0 + 1);
        chk("timeout_resp", n_resp, r0 + 1);
`else
        chk("hang_no_abort", n_abort, a0);
        chk("hang_no_resp", n_resp, r0);
`endif
        core_hang = 1'b0;
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
